dac_frame_decoder: RTL
======================

// Module: dac_frame_decoder
// PURPOSE
//  Receive end of the DAC8568 serial interface: oversamples sclk/nsync/din/nldac on the DAC clock and rebuilds each
//  32-bit write frame into ctrl/chan/data/feature fields with a one-cycle dv strobe. Sits on dac_clk beside
//  dac_controller for on-chip loopback check of DAC writes and for frame logging to the frontpanel interface.
// PARAMETERS
//  W_FRAME    32  bits per DAC8568 frame (prefix4|ctrl4|addr4|data16|feat4, MSB first)
//  W_DATA     16  data field width
//  W_CHAN     4   address field width
//  SYNC_STG   2   synchronizer flops per input (>=2)
//  W_CNT      16  width of frame and error counters
// PORTS
//  clk_in          in   1        DAC-domain clock (sclk_in period >= 4 clk_in periods)
//  rst_in          in   1        synchronous reset, active high
//  sclk_in         in   1        DAC serial clock; data sampled on its falling edge
//  nsync_in        in   1        frame enable, active low
//  din_in          in   1        serial data
//  nldac_in        in   1        load-DAC strobe, active low
//  dv_out          out  1        one-cycle strobe: fields valid
//  ctrl_out        out  4        frame bits [27:24]
//  chan_out        out  W_CHAN   frame bits [23:20]
//  data_out        out  W_DATA   frame bits [19:4]
//  feat_out        out  4        frame bits [3:0]
//  err_out         out  1        one-cycle strobe: frame rejected
//  ldac_out        out  1        one-cycle strobe on nldac falling edge
//  frame_cnt_out   out  W_CNT    good frames, wraps modulo 2^W_CNT
//  err_cnt_out     out  W_CNT    rejected frames, saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0; sync chains nsync/nldac to 1, sclk/din to 0; state IDLE; bit count 0; shift reg 0.
//  Edges: detected by comparing last sync stage with one extra delay flop; strobes registered next cycle, so
//   latency pin change -> dv/err/ldac strobe = SYNC_STG+1 clk_in edges.
//  FSM IDLE: nsync fall -> SHIFT, count=0, shift reg cleared. Level-low nsync without a fall (e.g. after reset
//   mid-frame) is ignored until nsync returns high and falls again.
//  SHIFT: each sclk fall shifts din in (MSB first), count++ (saturates at W_FRAME+1). nsync rise -> CLOSE.
//  CLOSE (1 cycle): count==W_FRAME -> dv_out=1, fields latched, frame_cnt++; else err_out=1, err_cnt++,
//   fields hold previous values. Returns to IDLE.
//  Short (<32) and long (>32) frames both rejected. sclk fall in same cycle as nsync rise: bit is shifted and
//   counted before evaluation. sclk edges while IDLE ignored. Fields hold until next good frame.
//  ldac_out independent of FSM; pulses on every nldac fall, including mid-frame.
//  rst_in mid-frame: aborts frame, no dv/err strobe, counters cleared.
// CONFIGURATION
//  DAC_DECODE_PREFIX_CHECK_EN defined: frame bits [31:28] must be 0000, else rejected (err path) even if
//   length is 32. Undefined: prefix ignored; any 32-bit frame yields dv.
// STRUCTURE
//  dac8568_defs.vh: W_FRAME, field bit offsets, prefix value, control codes (write/update, reset, ref setup).
//  Sub-module edge_sync: SYNC_STG flop chain + delay flop, outputs level/rise/fall; one instance per input.
// TESTING
//  Word 0x032ABCD0, sclk=clk/4 -> dv once, ctrl=3 chan=2 data=0xABCD feat=0, frame_cnt=1, latency SYNC_STG+1.
//  nsync high after 20 bits -> err_out once, no dv, err_cnt=1, data_out unchanged.
//  33 sclk falls in one frame -> err_out, no dv; following 0x03F12340 -> dv chan=0xF data=0x1234.
//  rst_in after 10 bits, nsync kept low -> no strobe; next full frame decoded normally.
//  0x832ABCD0 -> err with DAC_DECODE_PREFIX_CHECK_EN; dv data=0xABCD without it.
//  W_CNT=4, 17 good frames -> frame_cnt=1; nldac low 3 cycles mid-frame -> single ldac_out, frame intact.

Source files
------------

// File: rtl/dac_frame_decoder_pkg.sv
// Shared constants and state type for the DAC8568 frame decoder.
// Holds the frame layout (prefix|ctrl|addr|data|feat, MSB first) and the DAC8568 control codes.
package dac_frame_decoder_pkg;

  localparam int W_FRAME   = 32;
  localparam int W_BITCNT  = $clog2(W_FRAME + 2);
  localparam int W_CTRL    = 4;
  localparam int W_FEAT    = 4;
  localparam int W_PREFIX  = 4;

  localparam int PREFIX_LSB = 28;
  localparam int CTRL_LSB   = 24;
  localparam int CHAN_LSB   = 20;
  localparam int DATA_LSB   = 4;
  localparam int FEAT_LSB   = 0;

  localparam logic [W_PREFIX-1:0] PREFIX_VAL = 4'h0;

  // DAC8568 control codes carried in frame bits [27:24].
  localparam logic [W_CTRL-1:0] CTRL_WRITE_INPUT   = 4'h0;
  localparam logic [W_CTRL-1:0] CTRL_UPDATE        = 4'h1;
  localparam logic [W_CTRL-1:0] CTRL_WRITE_UPD_ALL = 4'h2;
  localparam logic [W_CTRL-1:0] CTRL_WRITE_UPDATE  = 4'h3;
  localparam logic [W_CTRL-1:0] CTRL_RESET         = 4'h7;
  localparam logic [W_CTRL-1:0] CTRL_REF_SETUP     = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

endpackage

// File: rtl/dac_frame_decoder_edge_sync.sv
// Synchronizer chain plus one delay flop; reports synced level and single-cycle rise/fall.
// RST_VAL sets the idle level the chain and delay flop take on reset.
module dac_frame_decoder_edge_sync #(
  parameter int   SYNC_STG = 2,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  logic [SYNC_STG-1:0] chain;
  logic                dly;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      chain <= {SYNC_STG{RST_VAL}};
      dly   <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STG-2:0], d_in};
      dly   <= chain[SYNC_STG-1];
    end
  end

  assign level_out = chain[SYNC_STG-1];
  assign rise_out  = chain[SYNC_STG-1] & ~dly;
  assign fall_out  = ~chain[SYNC_STG-1] & dly;

endmodule

// File: rtl/dac_frame_decoder.sv
// Rebuilds DAC8568 32-bit serial write frames (oversampled on clk_in) into fields with dv/err strobes.
// Optional `DAC_DECODE_PREFIX_CHECK_EN: reject frames whose bits [31:28] are not 0000.
module dac_frame_decoder
  import dac_frame_decoder_pkg::*;
#(
  parameter int W_DATA   = 16,
  parameter int W_CHAN   = 4,
  parameter int SYNC_STG = 2,
  parameter int W_CNT    = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              sclk_in,
  input  logic              nsync_in,
  input  logic              din_in,
  input  logic              nldac_in,
  output logic              dv_out,
  output logic [W_CTRL-1:0] ctrl_out,
  output logic [W_CHAN-1:0] chan_out,
  output logic [W_DATA-1:0] data_out,
  output logic [W_FEAT-1:0] feat_out,
  output logic              err_out,
  output logic              ldac_out,
  output logic [W_CNT-1:0]  frame_cnt_out,
  output logic [W_CNT-1:0]  err_cnt_out,
  output logic [1:0]        state_dbg_out
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic din_lvl, din_rise, din_fall;
  logic nsync_lvl, nsync_rise, nsync_fall;
  logic nldac_lvl, nldac_rise, nldac_fall;
  logic unused_edges;

  dac_frame_decoder_edge_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(sclk_in),
    .level_out(sclk_lvl), .rise_out(sclk_rise), .fall_out(sclk_fall));
  dac_frame_decoder_edge_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_din (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(din_in),
    .level_out(din_lvl), .rise_out(din_rise), .fall_out(din_fall));
  dac_frame_decoder_edge_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_nsync (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(nsync_in),
    .level_out(nsync_lvl), .rise_out(nsync_rise), .fall_out(nsync_fall));
  dac_frame_decoder_edge_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_nldac (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(nldac_in),
    .level_out(nldac_lvl), .rise_out(nldac_rise), .fall_out(nldac_fall));

  assign unused_edges = ^{sclk_lvl, sclk_rise, din_rise, din_fall, nldac_lvl, nldac_rise};

  state_t               state, state_nxt;
  logic [W_BITCNT-1:0]  cnt, cnt_nxt;
  logic [W_FRAME-1:0]   sh, sh_nxt;
  logic                 close_now, frame_ok;
  logic [SYNC_STG-1:0]  warm;
  logic                 armed;

  // A fall only opens a frame once nsync has been seen high with real (post-reset) samples,
  // so a reset that lands mid-frame cannot start decoding from the middle of a word.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    close_now = 1'b0;
    case (state)
      ST_IDLE: begin
        if (nsync_fall && armed) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
          sh_nxt    = '0;
        end
      end
      ST_SHIFT: begin
        if (sclk_fall) begin
          sh_nxt = {sh[W_FRAME-2:0], din_lvl};
          if (cnt != W_BITCNT'(W_FRAME + 1)) cnt_nxt = cnt + 1'b1;
        end
        if (nsync_rise) begin
          state_nxt = ST_CLOSE;
          close_now = 1'b1;
        end
      end
      ST_CLOSE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
`ifdef DAC_DECODE_PREFIX_CHECK_EN
    frame_ok = (cnt_nxt == W_BITCNT'(W_FRAME)) &&
               (sh_nxt[PREFIX_LSB +: W_PREFIX] == PREFIX_VAL);
`else
    frame_ok = (cnt_nxt == W_BITCNT'(W_FRAME));
`endif
  end

  // The verdict is registered on the nsync rise, so the strobes are high during the CLOSE cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      sh            <= '0;
      warm          <= '0;
      armed         <= 1'b0;
      dv_out        <= 1'b0;
      err_out       <= 1'b0;
      ldac_out      <= 1'b0;
      ctrl_out      <= '0;
      chan_out      <= '0;
      data_out      <= '0;
      feat_out      <= '0;
      frame_cnt_out <= '0;
      err_cnt_out   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sh       <= sh_nxt;
      warm     <= {warm[SYNC_STG-2:0], 1'b1};
      armed    <= armed | (warm[SYNC_STG-1] & nsync_lvl);
      dv_out   <= close_now & frame_ok;
      err_out  <= close_now & ~frame_ok;
      ldac_out <= nldac_fall;
      if (close_now && frame_ok) begin
        ctrl_out      <= sh_nxt[CTRL_LSB +: W_CTRL];
        chan_out      <= sh_nxt[CHAN_LSB +: W_CHAN];
        data_out      <= sh_nxt[DATA_LSB +: W_DATA];
        feat_out      <= sh_nxt[FEAT_LSB +: W_FEAT];
        frame_cnt_out <= frame_cnt_out + 1'b1;
      end
      if (close_now && !frame_ok && (err_cnt_out != {W_CNT{1'b1}}))
        err_cnt_out <= err_cnt_out + 1'b1;
    end
  end

  assign state_dbg_out = state;

endmodule
